// File: rtl/nyuzi_axi_rd_upsizer.sv
// nyuzi_axi_rd_upsizer
//   Read-channel width adapter between the wide Nyuzi core AXI master and a
//   narrower memory port. Each core read burst is issued to memory as a burst
//   RATIO times longer. Every RATIO narrow beats are packed into one wide core
//   beat, with narrow beat k placed at bits [k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH].
//   Only one request is in flight at a time. Neither side carries rlast, so the
//   beat counters alone mark where a burst ends.
//
//   Ports
//     clk, reset                  single clock, synchronous active-high reset
//     core_ar* (addr/len/valid)   core read request in, core_arready out
//     core_r*  (data/valid)       packed wide beat out, core_rready in
//     mem_ar*  (addr/len/valid)   memory read request out, mem_arready in
//     mem_r*   (data/valid)       narrow beat in, mem_rready out
//
//   Build option
//     NYUZI_RD_UPSIZER_PIPELINE_EN : when defined, a separate assembly register
//     sits behind the output register. Narrow beats keep flowing while a wide
//     beat waits for core_rready. When undefined, one register does both jobs
//     and the memory side is held off while a wide beat is pending.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a core request; core_arready high
//   ADDR  | memory request presented; held stable until mem_arready
//   DATA  | collecting narrow beats, presenting wide beats to the core

module nyuzi_axi_rd_upsizer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CORE_DATA_WIDTH = 512,
  parameter int MEM_DATA_WIDTH  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      core_araddr,
  input  logic [7:0]                 core_arlen,
  input  logic                       core_arvalid,
  output logic                       core_arready,
  output logic [CORE_DATA_WIDTH-1:0] core_rdata,
  output logic                       core_rvalid,
  input  logic                       core_rready,
  output logic [ADDR_WIDTH-1:0]      mem_araddr,
  output logic [7:0]                 mem_arlen,
  output logic                       mem_arvalid,
  input  logic                       mem_arready,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_rdata,
  input  logic                       mem_rvalid,
  output logic                       mem_rready
);

  localparam int RATIO = CORE_DATA_WIDTH / MEM_DATA_WIDTH;
  localparam int NB_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OFF_W = $clog2(CORE_DATA_WIDTH / 8);
  localparam logic [NB_W-1:0] LAST_NB = NB_W'(RATIO - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    {{(ADDR_WIDTH - OFF_W){1'b1}}, {OFF_W{1'b0}}};

  generate
    if ((RATIO < 1) || ((RATIO & (RATIO - 1)) != 0) ||
        (RATIO * MEM_DATA_WIDTH != CORE_DATA_WIDTH)) begin : g_bad_ratio
      $error("nyuzi_axi_rd_upsizer: CORE_DATA_WIDTH/MEM_DATA_WIDTH must be a power of two >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 arlen_q, arlen_d;
  logic [7:0]                 cbeat_q, cbeat_d;
  logic [NB_W-1:0]            nbeat_q, nbeat_d;
  logic [ADDR_WIDTH-1:0]      mem_araddr_q, mem_araddr_d;
  logic [7:0]                 mem_arlen_q, mem_arlen_d;
  logic [CORE_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                       rvalid_q, rvalid_d;
`ifdef NYUZI_RD_UPSIZER_PIPELINE_EN
  logic [CORE_DATA_WIDTH-1:0] asm_q, asm_d;
`endif

  logic [31:0]                mem_beats;
  logic [CORE_DATA_WIDTH-1:0] merged;
  logic                       mem_hs;
  logic                       core_hs;

  // Narrow beat count for the incoming request. Kept at 32 bits so an
  // oversize burst is visible to the check below; the issued length is the
  // low 8 bits only.
  assign mem_beats = (32'(core_arlen) + 32'd1) * 32'(RATIO);

  assign core_arready = (state_q == IDLE);
  assign mem_arvalid  = (state_q == ADDR);
  assign mem_araddr   = mem_araddr_q;
  assign mem_arlen    = mem_arlen_q;
  assign core_rdata   = rdata_q;
  assign core_rvalid  = rvalid_q;

`ifdef NYUZI_RD_UPSIZER_PIPELINE_EN
  // Hold off memory only when the beat about to arrive would complete a wide
  // word while the output register is still occupied and not draining.
  assign mem_rready = (state_q == DATA) &&
                      !(rvalid_q && !core_rready && (nbeat_q == LAST_NB));
`else
  assign mem_rready = (state_q == DATA) && !rvalid_q;
`endif

  assign mem_hs  = mem_rvalid && mem_rready;
  assign core_hs = rvalid_q && core_rready;

  always_comb begin
    state_d      = state_q;
    arlen_d      = arlen_q;
    cbeat_d      = cbeat_q;
    nbeat_d      = nbeat_q;
    mem_araddr_d = mem_araddr_q;
    mem_arlen_d  = mem_arlen_q;
    rdata_d      = rdata_q;
    rvalid_d     = rvalid_q;
`ifdef NYUZI_RD_UPSIZER_PIPELINE_EN
    asm_d        = asm_q;
    merged       = asm_q;
`else
    merged       = rdata_q;
`endif

    // Partial word with the current narrow beat dropped into its lane.
    for (int k = 0; k < RATIO; k++) begin
      if (NB_W'(k) == nbeat_q) begin
        merged[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rdata;
      end
    end

    case (state_q)
      IDLE: begin
        if (core_arvalid) begin
          arlen_d      = core_arlen;
          mem_araddr_d = core_araddr & ADDR_MASK;
          mem_arlen_d  = 8'(mem_beats - 32'd1);
          state_d      = ADDR;
        end
      end

      ADDR: begin
        if (mem_arready) begin
          cbeat_d  = '0;
          nbeat_d  = '0;
          rvalid_d = 1'b0;
          state_d  = DATA;
        end
      end

      DATA: begin
        if (core_hs) begin
          rvalid_d = 1'b0;
          if (cbeat_q == arlen_q) begin
            cbeat_d = '0;
            state_d = IDLE;
          end else begin
            cbeat_d = cbeat_q + 8'd1;
          end
        end
        // A completed word reloads the output register; this takes priority
        // over the drain above, which only happens in the pipelined build.
        if (mem_hs) begin
          if (nbeat_q == LAST_NB) begin
            rdata_d  = merged;
            rvalid_d = 1'b1;
            nbeat_d  = '0;
          end else begin
`ifdef NYUZI_RD_UPSIZER_PIPELINE_EN
            asm_d    = merged;
`else
            rdata_d  = merged;
`endif
            nbeat_d  = nbeat_q + NB_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      arlen_q      <= '0;
      cbeat_q      <= '0;
      nbeat_q      <= '0;
      mem_araddr_q <= '0;
      mem_arlen_q  <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
`ifdef NYUZI_RD_UPSIZER_PIPELINE_EN
      asm_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      arlen_q      <= arlen_d;
      cbeat_q      <= cbeat_d;
      nbeat_q      <= nbeat_d;
      mem_araddr_q <= mem_araddr_d;
      mem_arlen_q  <= mem_arlen_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
`ifdef NYUZI_RD_UPSIZER_PIPELINE_EN
      asm_q        <= asm_d;
`endif
    end
  end

  // A narrow burst longer than 256 beats cannot be expressed in mem_arlen.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == IDLE) && core_arvalid) begin
      assert (mem_beats <= 32'd256)
        else $error("nyuzi_axi_rd_upsizer: burst of %0d narrow beats exceeds 256", mem_beats);
    end
  end

endmodule
